spi_transaction_fsm: RTL

Controller that sequences the 8-bit shift register and data memory for the SPI memory peripheral. It counts conditioned SCLK edges while chip select is low and decodes the address/RW byte. It issues the shift register's parallel load, the address latch enable, the data-memory write enable and the MISO tri-state enable. The block sits between the input conditioners (synchronised SCLK edges, CS) and the shiftregister, address latch, memory and MISO buffer.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_bit_counter.sv | 39 +++
 rtl/spi_transaction_fsm.sv | 101 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and constants for the SPI memory transaction controller.
// Defining BURST_EN adds the address-increment state used for multi-byte bursts.
package spi_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam logic        RW_READ       = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGotAddr,
    StReadWait,
    StReadLoad,
    StReadShift,
    StWriteShift,
    StWriteMem,
    StDone
`ifdef BURST_EN
    ,
    StIncr
`endif
  } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating SCLK-edge counter with synchronous clear and a terminal-edge flag.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the edge that brings the count to WIDTH, so the FSM can leave on that same clk.
  assign last_o = en_i && (cnt_q == (MaxCnt - 1'b1));

endmodule

// File: rtl/spi_transaction_fsm.sv
// Sequences address/data phases of the SPI memory peripheral from conditioned SCLK/CS.
// Optional BURST_EN: auto-increment the address and continue while CS stays low.
module spi_transaction_fsm
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic resetN,
  input  logic sclkPosEdge,
  input  logic chipSelect,
  input  logic rwBit,
  output logic addrLatchEn,
  output logic srParallelLoad,
  output logic dmWriteEn,
  output logic misoBufEn,
  output logic addrIncrement,
  output logic busy
);

  spi_state_e state_q, state_d;
  logic       shifting, cnt_en, cnt_clr, cnt_last;

  assign shifting = (state_q == StGetAddr) || (state_q == StReadShift) ||
                    (state_q == StWriteShift);
  assign cnt_en   = shifting && sclkPosEdge;
  assign cnt_clr  = !shifting || (state_d != state_q);

  spi_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk_i (clk),
    .rst_ni(resetN),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .last_o(cnt_last)
  );

`ifdef BURST_EN
  // rwBit is overwritten by data bits during the burst, so remember the direction.
  logic rw_q;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rw_q <= 1'b0;
    end else if (state_q == StGotAddr) begin
      rw_q <= rwBit;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // CS high aborts everywhere except a write strobe already under way.
    if (chipSelect && (state_q != StIdle) && (state_q != StWriteMem)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:       if (!chipSelect) state_d = StGetAddr;
        StGetAddr:    if (cnt_last) state_d = StGotAddr;
        StGotAddr:    state_d = (rwBit == RW_READ) ? StReadWait : StWriteShift;
        StReadWait:   state_d = StReadLoad;
        StReadLoad:   state_d = StReadShift;
`ifdef BURST_EN
        StReadShift:  if (cnt_last) state_d = StIncr;
        StWriteMem:   state_d = chipSelect ? StDone : StIncr;
        StIncr:       state_d = (rw_q == RW_READ) ? StReadWait : StWriteShift;
`else
        StReadShift:  if (cnt_last) state_d = StDone;
        StWriteMem:   state_d = StDone;
`endif
        StWriteShift: if (cnt_last) state_d = StWriteMem;
        StDone:       state_d = StDone;
        default:      state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    addrLatchEn    = (state_q == StGotAddr);
    srParallelLoad = (state_q == StReadLoad);
    dmWriteEn      = (state_q == StWriteMem);
    misoBufEn      = (state_q == StReadShift);
    busy           = (state_q != StIdle);
`ifdef BURST_EN
    addrIncrement  = (state_q == StIncr);
`else
    addrIncrement  = 1'b0;
`endif
  end

endmodule
